// File: rtl/sdram_axi_cpu_master.sv
// rtl/sdram_axi_cpu_master.sv - CPU request to single-beat/line AXI master bridge
//
// Purpose: turns a held CPU request (mem_req_i ... mem_ack_o) into one AXI write
// (AW + W + B) or one AXI read burst (AR + R). One transfer outstanding at a time.
//
// Optional feature macro: SDRAM_AXI_CPU_LINEBUF_EN
//   defined   - reads fetch a whole 16-byte line (arlen=3) into a 4x32 line buffer;
//               read hits complete without AXI traffic, matching writes update it.
//   undefined - reads fetch a single word (arlen=0), no buffer.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   mem_req_i/we_i/addr_i        CPU request, direction, byte address
//   mem_wdata_i/wstrb_i          CPU write data and byte enables
//   mem_ack_o/rdata_o/error_o    one-cycle completion, read data, error flag
//   outport_aw*/w*/b*            AXI write address, data and response channels
//   outport_ar*/r*               AXI read address and data channels
module sdram_axi_cpu_master (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ack_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_error_o,
    output logic        outport_awvalid_o,
    input  logic        outport_awready_i,
    output logic [31:0] outport_awaddr_o,
    output logic [7:0]  outport_awlen_o,
    output logic [1:0]  outport_awburst_o,
    output logic        outport_wvalid_o,
    input  logic        outport_wready_i,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_wlast_o,
    input  logic        outport_bvalid_i,
    output logic        outport_bready_o,
    input  logic [1:0]  outport_bresp_i,
    output logic        outport_arvalid_o,
    input  logic        outport_arready_i,
    output logic [31:0] outport_araddr_o,
    output logic [7:0]  outport_arlen_o,
    output logic [1:0]  outport_arburst_o,
    input  logic        outport_rvalid_i,
    output logic        outport_rready_o,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    input  logic        outport_rlast_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

`ifdef SDRAM_AXI_CPU_LINEBUF_EN
    localparam logic [7:0] ARLEN = 8'd3;
`else
    localparam logic [7:0] ARLEN = 8'd0;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [31:2] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;
    logic [7:0]  r_beat;
    logic        r_error;
    logic [31:0] r_rdata;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_rd_last;
    logic        w_hit;
    logic        w_unused_addr;

`ifdef SDRAM_AXI_CPU_LINEBUF_EN
    logic [31:0] r_line [4];
    logic [31:4] r_tag;
    logic        r_line_valid;

    assign w_hit = r_line_valid && (mem_addr_i[31:4] == r_tag);
`else
    assign w_hit = 1'b0;
`endif

    assign w_unused_addr = ^mem_addr_i[1:0];

    // AXI channel outputs are pure decodes of registered state, so they stay
    // stable while valid and drop only after their own handshake.
    assign outport_awvalid_o = (r_state == S_WADDR) && !r_aw_done;
    assign outport_awaddr_o  = {r_addr, 2'b00};
    assign outport_awlen_o   = 8'd0;
    assign outport_awburst_o = 2'b01;
    assign outport_wvalid_o  = (r_state == S_WADDR) && !r_w_done;
    assign outport_wdata_o   = r_wdata;
    assign outport_wstrb_o   = r_wstrb;
    assign outport_wlast_o   = 1'b1;
    assign outport_bready_o  = (r_state == S_WRESP);
    assign outport_arvalid_o = (r_state == S_RADDR);
`ifdef SDRAM_AXI_CPU_LINEBUF_EN
    assign outport_araddr_o  = {r_addr[31:4], 4'b0000};
`else
    assign outport_araddr_o  = {r_addr, 2'b00};
`endif
    assign outport_arlen_o   = ARLEN;
    assign outport_arburst_o = 2'b01;
    assign outport_rready_o  = (r_state == S_RDATA);

    assign mem_ack_o   = (r_state == S_DONE);
    assign mem_error_o = (r_state == S_DONE) && r_error;
    assign mem_rdata_o = r_rdata;

    assign w_aw_hs   = outport_awvalid_o && outport_awready_i;
    assign w_w_hs    = outport_wvalid_o && outport_wready_i;
    assign w_rd_last = outport_rvalid_i && (outport_rlast_i || (r_beat == ARLEN));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_req_i) begin
                    if (mem_we_i)
                        w_next = S_WADDR;
                    else if (w_hit)
                        w_next = S_DONE;
                    else
                        w_next = S_RADDR;
                end
            end
            // AW and W may complete in either order or together.
            S_WADDR: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    w_next = S_WRESP;
            end
            S_WRESP: if (outport_bvalid_i) w_next = S_DONE;
            S_RADDR: if (outport_arready_i) w_next = S_RDATA;
            S_RDATA: if (w_rd_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_beat    <= '0;
            r_error   <= 1'b0;
            r_rdata   <= '0;
`ifdef SDRAM_AXI_CPU_LINEBUF_EN
            r_tag        <= '0;
            r_line_valid <= 1'b0;
            for (int i = 0; i < 4; i++) r_line[i] <= '0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (mem_req_i) begin
                        r_addr    <= mem_addr_i[31:2];
                        r_wdata   <= mem_wdata_i;
                        r_wstrb   <= mem_wstrb_i;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_beat    <= '0;
                        r_error   <= 1'b0;
`ifdef SDRAM_AXI_CPU_LINEBUF_EN
                        if (mem_we_i) begin
                            // Write-through: keep a buffered line coherent.
                            if (w_hit) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (mem_wstrb_i[b])
                                        r_line[mem_addr_i[3:2]][8*b +: 8] <= mem_wdata_i[8*b +: 8];
                                end
                            end
                        end else if (w_hit) begin
                            r_rdata <= r_line[mem_addr_i[3:2]];
                        end else begin
                            r_line_valid <= 1'b0;
                            r_tag        <= mem_addr_i[31:4];
                        end
`endif
                    end
                end
                S_WADDR: begin
                    r_aw_done <= r_aw_done || w_aw_hs;
                    r_w_done  <= r_w_done || w_w_hs;
                end
                S_WRESP: begin
                    if (outport_bvalid_i)
                        r_error <= (outport_bresp_i != 2'b00);
                end
                S_RDATA: begin
                    if (outport_rvalid_i) begin
                        r_beat <= r_beat + 8'd1;
                        if (outport_rresp_i != 2'b00)
                            r_error <= 1'b1;
`ifdef SDRAM_AXI_CPU_LINEBUF_EN
                        r_line[r_beat[1:0]] <= outport_rdata_i;
                        if (r_beat[1:0] == r_addr[3:2])
                            r_rdata <= outport_rdata_i;
                        // Line is usable only if all four beats arrived without error.
                        if (w_rd_last)
                            r_line_valid <= !r_error && (outport_rresp_i == 2'b00) && (r_beat == ARLEN);
`else
                        if (r_beat == 8'd0)
                            r_rdata <= outport_rdata_i;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_axi_cpu_master.sv
// tb/tb_sdram_axi_cpu_master.sv - self-checking bench for sdram_axi_cpu_master
module tb_sdram_axi_cpu_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ack, mem_error;
    logic [31:0] mem_rdata;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    sdram_axi_cpu_master dut (
        .clk_i(clk), .rst_i(rst),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb),
        .mem_ack_o(mem_ack), .mem_rdata_o(mem_rdata), .mem_error_o(mem_error),
        .outport_awvalid_o(awvalid), .outport_awready_i(awready),
        .outport_awaddr_o(awaddr), .outport_awlen_o(awlen), .outport_awburst_o(awburst),
        .outport_wvalid_o(wvalid), .outport_wready_i(wready),
        .outport_wdata_o(wdata), .outport_wstrb_o(wstrb), .outport_wlast_o(wlast),
        .outport_bvalid_i(bvalid), .outport_bready_o(bready), .outport_bresp_i(bresp),
        .outport_arvalid_o(arvalid), .outport_arready_i(arready),
        .outport_araddr_o(araddr), .outport_arlen_o(arlen), .outport_arburst_o(arburst),
        .outport_rvalid_i(rvalid), .outport_rready_o(rready),
        .outport_rdata_i(rdata), .outport_rresp_i(rresp), .outport_rlast_i(rlast)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave configuration and observation
    int          cfg_aw = 0, cfg_w = 0, cfg_err_beat = -1;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rbase = '0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, viol;
    logic [31:0] log_addr, log_wdata;
    logic [7:0]  log_len;
    logic [3:0]  log_wstrb;

    int          aw_wait, w_wait, r_beat;
    logic        aw_got, w_got, b_issued, b_pend, r_pend;
    logic [7:0]  r_len;
    logic        p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    initial begin
        {awready, wready, bvalid, arready, rvalid, rlast} = '0;
        bresp = '0; rresp = '0; rdata = '0;
        {aw_got, w_got, b_issued, b_pend, r_pend, p_aw, p_w, p_ar} = '0;
        aw_wait = 0; w_wait = 0; r_beat = 0; r_len = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; viol = 0;
        p_awaddr = '0; p_wdata = '0; p_araddr = '0;
        log_addr = '0; log_wdata = '0; log_len = '0; log_wstrb = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                {awready, wready, bvalid, arready, rvalid, rlast} = '0;
                bresp = '0; rresp = '0;
            end else begin
                awready = awvalid && (aw_wait >= cfg_aw);
                wready  = wvalid && (w_wait >= cfg_w);
                arready = arvalid;
                bvalid  = b_pend;
                bresp   = b_pend ? cfg_bresp : 2'b00;
                rvalid  = r_pend;
                rdata   = cfg_rbase + r_beat;
                rresp   = (r_pend && r_beat == cfg_err_beat) ? cfg_rresp : 2'b00;
                rlast   = r_pend && (r_beat == int'(r_len));
            end
            @(negedge clk);
            if (rst) begin
                {aw_got, w_got, b_issued, b_pend, r_pend, p_aw, p_w, p_ar} = '0;
                aw_wait = 0; w_wait = 0; r_beat = 0;
            end else begin
                if (p_aw && (!awvalid || awaddr != p_awaddr)) viol++;
                if (p_w && (!wvalid || wdata != p_wdata)) viol++;
                if (p_ar && (!arvalid || araddr != p_araddr)) viol++;
                p_aw = awvalid && !awready; p_awaddr = awaddr;
                p_w  = wvalid && !wready;   p_wdata  = wdata;
                p_ar = arvalid && !arready; p_araddr = araddr;
                if (awvalid && aw_got) viol++;
                if (wvalid && w_got) viol++;
                if (awvalid) begin
                    if (awready) begin
                        aw_cnt++; log_addr = awaddr; log_len = awlen;
                        if (awlen != 8'd0 || awburst != 2'b01) viol++;
                        aw_got = 1'b1; aw_wait = 0;
                    end else aw_wait++;
                end
                if (wvalid) begin
                    if (wready) begin
                        w_cnt++; log_wdata = wdata; log_wstrb = wstrb;
                        if (!wlast) viol++;
                        w_got = 1'b1; w_wait = 0;
                    end else w_wait++;
                end
                if (bvalid && bready) begin
                    b_pend = 1'b0; b_cnt++;
                    aw_got = 1'b0; w_got = 1'b0; b_issued = 1'b0;
                end else if (aw_got && w_got && !b_issued) begin
                    b_pend = 1'b1; b_issued = 1'b1;
                end
                if (rvalid && rready) begin
                    if (r_beat == int'(r_len)) r_pend = 1'b0;
                    r_beat++;
                end
                if (arvalid && arready) begin
                    ar_cnt++; log_addr = araddr; log_len = arlen;
                    if (arburst != 2'b01) viol++;
                    r_pend = 1'b1; r_beat = 0; r_len = arlen;
                end
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  bresp;
        logic [31:0] rbase;
        int          err_beat;
        logic [1:0]  rresp;
        int          exp_lat;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_axaddr;
        logic [7:0]  exp_len;
        int          exp_aw;
        int          exp_ar;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        logic got, er, ack_after;
        logic [31:0] rd;
        cfg_aw = v.aw_dly; cfg_w = v.w_dly; cfg_bresp = v.bresp;
        cfg_rbase = v.rbase; cfg_err_beat = v.err_beat; cfg_rresp = v.rresp;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; viol = 0;
        @(posedge clk); #1;
        mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata; mem_wstrb = v.wstrb;
        mem_req = 1'b1;
        lat = 0; got = 1'b0; er = 1'b0; rd = '0;
        while (lat < 60 && !got) begin
            @(negedge clk);
            lat++;
            if (mem_ack) begin got = 1'b1; rd = mem_rdata; er = mem_error; end
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
        @(negedge clk);
        ack_after = mem_ack;
        chk({tag, "_acked"}, {31'd0, got}, 32'd1);
        chk({tag, "_latency"}, lat, v.exp_lat);
        chk({tag, "_ack_one_cycle"}, {31'd0, ack_after}, 32'd0);
        chk({tag, "_error"}, {31'd0, er}, {31'd0, v.exp_err});
        if (v.chk_rdata) chk({tag, "_rdata"}, rd, v.exp_rdata);
        chk({tag, "_aw_count"}, aw_cnt, v.exp_aw);
        chk({tag, "_w_count"}, w_cnt, v.exp_aw);
        chk({tag, "_b_count"}, b_cnt, v.exp_aw);
        chk({tag, "_ar_count"}, ar_cnt, v.exp_ar);
        chk({tag, "_protocol"}, viol, 0);
        if (v.exp_aw + v.exp_ar > 0) begin
            chk({tag, "_axaddr"}, log_addr, v.exp_axaddr);
            chk({tag, "_axlen"}, {24'd0, log_len}, {24'd0, v.exp_len});
        end
        if (v.exp_aw > 0) begin
            chk({tag, "_wdata"}, log_wdata, v.wdata);
            chk({tag, "_wstrb"}, {28'd0, log_wstrb}, {28'd0, v.wstrb});
        end
    endtask

    vec_t vecs [$];
    vec_t post_rst;

    initial begin
        //        we  addr          wdata         strb  awd wd bresp  rbase         eb  rresp  lat chk rdata         err axaddr        len  aw ar
        vecs.push_back('{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 32'h0, -1, 2'b00, 4, 1'b0, 32'h0, 1'b0, 32'h0000_0100, 8'd0, 1, 0});
        vecs.push_back('{1'b1, 32'h0000_0107, 32'h1234_5678, 4'h3, 3, 0, 2'b00, 32'h0, -1, 2'b00, 7, 1'b0, 32'h0, 1'b0, 32'h0000_0104, 8'd0, 1, 0});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h8, 0, 2, 2'b10, 32'h0, -1, 2'b00, 6, 1'b0, 32'h0, 1'b1, 32'h0000_0010, 8'd0, 1, 0});
`ifdef SDRAM_AXI_CPU_LINEBUF_EN
        vecs.push_back('{1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 2'b00, 32'hA5A5_0000, -1, 2'b00, 7, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0000_0100, 8'd3, 0, 1});
        vecs.push_back('{1'b0, 32'h0000_010C, 32'h0, 4'h0, 0, 0, 2'b00, 32'h0, -1, 2'b00, 2, 1'b1, 32'hA5A5_0003, 1'b0, 32'h0, 8'd0, 0, 0});
        vecs.push_back('{1'b1, 32'h0000_0108, 32'h1122_3344, 4'h6, 0, 0, 2'b00, 32'h0, -1, 2'b00, 4, 1'b0, 32'h0, 1'b0, 32'h0000_0108, 8'd0, 1, 0});
        vecs.push_back('{1'b0, 32'h0000_0108, 32'h0, 4'h0, 0, 0, 2'b00, 32'h0, -1, 2'b00, 2, 1'b1, 32'hA522_3302, 1'b0, 32'h0, 8'd0, 0, 0});
        vecs.push_back('{1'b0, 32'h0000_0208, 32'h0, 4'h0, 0, 0, 2'b00, 32'h5A00_0000, 2, 2'b10, 7, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 8'd3, 0, 1});
        vecs.push_back('{1'b0, 32'h0000_020C, 32'h0, 4'h0, 0, 0, 2'b00, 32'h5A00_0000, -1, 2'b00, 7, 1'b1, 32'h5A00_0003, 1'b0, 32'h0000_0200, 8'd3, 0, 1});
        post_rst = '{1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 2'b00, 32'h7700_0000, -1, 2'b00, 7, 1'b1, 32'h7700_0001, 1'b0, 32'h0000_0100, 8'd3, 0, 1};
`else
        vecs.push_back('{1'b0, 32'h0000_0204, 32'h0, 4'h0, 0, 0, 2'b00, 32'hA5A5_0000, -1, 2'b00, 4, 1'b1, 32'hA5A5_0000, 1'b0, 32'h0000_0204, 8'd0, 0, 1});
        vecs.push_back('{1'b0, 32'h0000_020B, 32'h0, 4'h0, 0, 0, 2'b00, 32'h5A00_0000, 0, 2'b10, 4, 1'b0, 32'h0, 1'b1, 32'h0000_0208, 8'd0, 0, 1});
        vecs.push_back('{1'b0, 32'h0000_020B, 32'h0, 4'h0, 0, 0, 2'b00, 32'h0000_0077, -1, 2'b00, 4, 1'b1, 32'h0000_0077, 1'b0, 32'h0000_0208, 8'd0, 0, 1});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h0BAD_0BAD, 4'h0, 1, 1, 2'b11, 32'h0, -1, 2'b00, 5, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 8'd0, 1, 0});
        post_rst = '{1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 2'b00, 32'h7700_0000, -1, 2'b00, 4, 1'b1, 32'h7700_0000, 1'b0, 32'h0000_0104, 8'd0, 0, 1};
`endif

        // Reset state
        #12;
        chk("reset_outputs", {25'd0, mem_ack, mem_error, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        chk("reset_rdata", mem_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a read burst
        begin
            int n;
            cfg_aw = 0; cfg_w = 0; cfg_err_beat = -1; cfg_rbase = 32'hC0DE_0000;
            @(posedge clk); #1;
            mem_we = 1'b0; mem_addr = 32'h0000_0400; mem_req = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rready && n < 20);
            chk("midrst_reached_rdata", {31'd0, rready}, 32'd1);
            #1 rst = 1'b1;
            mem_req = 1'b0;
            #1;
            chk("midrst_outputs", {25'd0, mem_ack, mem_error, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
            chk("midrst_rdata", mem_rdata, 32'd0);
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            run_vec(post_rst, "post_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
